stage_step_ctrl: RTL and testbench
==================================

// Module: stage_step_ctrl
// PURPOSE
//  Step source for the multi-cycle CPU's STAGES sequencer. It turns the raw nextStage push-button
//  into a debounced single-cycle step, and turns isAuto into a periodic step tick. It tracks the
//  current stage index and counts retired instructions. It sits between board I/O and STAGES.
//  STAGES consumes step_pulse as its advance strobe.
// PARAMETERS
//  DB_COUNT   50000     stable cycles a button level must hold before it is accepted (>=2)
//  DB_W       16        width of debounce counter; must hold DB_COUNT
//  AUTO_DIV   25000000  clk cycles between auto steps (>=2)
//  AUTO_W     25        width of auto divider; must hold AUTO_DIV-1
//  STAGE_NUM  5         stages per instruction; stage runs 0..STAGE_NUM-1 (<=8)
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             asynchronous reset, active-high
//  isAuto     in   1             raw switch: 1 = auto stepping, 0 = manual
//  nextStage  in   1             raw push-button, active-high, bouncy
//  hold       in   1             STAGES busy (memory write in progress): defer steps
//  step_pulse out  1             one-cycle advance strobe to STAGES
//  stage      out  3             current stage index
//  stage_wrap out  1             one-cycle pulse in the cycle stage returns to 0
//  ins_count  out  `WORD_SIZE    retired-instruction counter
// BEHAVIOUR
//  - Reset (async, rst=1): all flops clear and all outputs go 0 immediately; FSM=IDLE; pending=0.
//    Reset mid-press: after release of rst, a still-held button needs a fresh DB_COUNT before
//    it is accepted.
//  - isAuto and nextStage each pass through a 2-FF synchroniser (btn_s, auto_s).
//  - Debounce FSM, 4 states. db_cnt clears on every state change:
//    IDLE: btn_s=1 -> PRESS_WAIT.
//    PRESS_WAIT: btn_s=0 -> IDLE. db_cnt reaches DB_COUNT-1 -> PRESSED, emit man_req for 1 cycle.
//    PRESSED: btn_s=0 -> REL_WAIT.
//    REL_WAIT: btn_s=1 -> PRESSED, with no new man_req. db_cnt reaches DB_COUNT-1 -> IDLE.
//    Exactly one man_req per accepted press.
//  - Auto divider, running when auto_s=1: counts 0..AUTO_DIV-1, then wraps to 0.
//    It emits auto_req in the cycle it reaches AUTO_DIV-1.
//    When auto_s=0 the divider is held at 0.
//  - req = auto_s ? auto_req : man_req. Button presses are ignored in auto mode; the FSM still runs.
//  - Pending flag:
//    Set by req. Cleared when a step issues.
//    A req while pending=1 is dropped; at most 1 step is ever queued.
//    Any change of auto_s clears pending and the divider.
//  - step_pulse is registered. It is high in cycle N+1 if pending was 1 at the edge ending cycle N,
//    or req was 1 in cycle N, and hold=0 in cycle N.
//    With hold=0, latency req -> step_pulse is 1 cycle. hold=1 defers the step indefinitely.
//  - In the same edge as step_pulse rises:
//    stage <= (stage==STAGE_NUM-1) ? 0 : stage+1.
//    stage_wrap <= 1 exactly when stage becomes 0 by wrap.
//    On wrap, ins_count <= ins_count+1, modulo 2^`WORD_SIZE; all-ones wraps to 0.
// CONFIGURATION
//  - STEP_DEBOUNCE_EN defined: debounce FSM as above.
//  - STEP_DEBOUNCE_EN undefined: FSM and db_cnt are removed. man_req = rising edge of btn_s,
//    1 cycle, every edge (simulation speed).
//  - All other behaviour is identical in both builds.
// TESTING
//  Bench params: DB_COUNT=4, AUTO_DIV=8, STAGE_NUM=5, STEP_DEBOUNCE_EN defined unless stated.
//  1. Reset: rst=1 asynchronously mid-run at stage=3, ins_count=7.
//     -> stage=0, ins_count=0, step_pulse=0, stage_wrap=0 before the next clk edge.
//  2. Clean press: nextStage high 10 cycles, then low 10 cycles.
//     -> exactly one step_pulse; stage 0->1.
//  3. Bounce: nextStage 1,0,1,0 (1 cycle each), then high 10 cycles.
//     -> exactly one step_pulse.
//  4. Auto: isAuto=1 for 84 cycles, hold=0.
//     -> step_pulse spaced exactly 8 cycles; 10 pulses; stage_wrap twice; ins_count=2; stage=0.
//  5. Hold: hold=1; auto_req occurs twice.
//     -> no step_pulse during hold. Release hold -> exactly one step_pulse the next cycle.
//  6. STEP_DEBOUNCE_EN undefined: nextStage high 1 cycle.
//     -> one step_pulse, 4 cycles after the raw rise (2 sync + edge + issue).

Source files
------------

// File: rtl/stage_step_ctrl.sv
// stage_step_ctrl: step source for the STAGES sequencer.
//   Turns the bouncy nextStage button into one clean step request per press and isAuto into a
//   periodic step tick. It keeps at most one step queued while STAGES signals hold, tracks the
//   stage index and counts retired instructions.
// Configuration macro: STEP_DEBOUNCE_EN
//   defined   -> 4-state debounce FSM with a DB_COUNT-cycle stability counter
//   undefined -> every rising edge of the synchronised button is a request (fast simulation)
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   isAuto      raw switch, 1 = auto stepping
//   nextStage   raw push-button, active-high
//   hold        STAGES busy: steps are deferred while high
//   step_pulse  registered one-cycle advance strobe
//   stage       current stage index, 0..STAGE_NUM-1
//   stage_wrap  registered one-cycle pulse when stage wraps back to 0
//   ins_count   retired-instruction counter, width `WORD_SIZE
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module stage_step_ctrl #(
    parameter int unsigned DB_COUNT  = 50000,
    parameter int unsigned DB_W      = 16,
    parameter int unsigned AUTO_DIV  = 25000000,
    parameter int unsigned AUTO_W    = 25,
    parameter int unsigned STAGE_NUM = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   isAuto,
    input  logic                   nextStage,
    input  logic                   hold,
    output logic                   step_pulse,
    output logic [2:0]             stage,
    output logic                   stage_wrap,
    output logic [`WORD_SIZE-1:0]  ins_count
);

    localparam int unsigned          WORD_W     = `WORD_SIZE;
    localparam logic [2:0]           STAGE_LAST = 3'(STAGE_NUM - 1);
    localparam logic [AUTO_W-1:0]    AUTO_LAST  = AUTO_W'(AUTO_DIV - 1);

    // Elaboration-time parameter sanity checks
    if ((DB_COUNT < 2) || ((64'(DB_COUNT) >> DB_W) != 64'd0)) begin : g_db_param_err
        $error("stage_step_ctrl: DB_COUNT must be >= 2 and fit in DB_W bits");
    end
    if ((AUTO_DIV < 2) || ((64'(AUTO_DIV - 1) >> AUTO_W) != 64'd0)) begin : g_auto_param_err
        $error("stage_step_ctrl: AUTO_DIV must be >= 2 and AUTO_DIV-1 fit in AUTO_W bits");
    end
    if ((STAGE_NUM < 1) || (STAGE_NUM > 8)) begin : g_stage_param_err
        $error("stage_step_ctrl: STAGE_NUM must be in 1..8");
    end

    // Synchronisers, bit 1 is the synchronised level
    logic [1:0] btn_sync_q, auto_sync_q;
    logic       btn_s, auto_s;
    logic       auto_prev_q;
    logic       mode_chg;
    logic       man_req;

    assign btn_s    = btn_sync_q[1];
    assign auto_s   = auto_sync_q[1];
    assign mode_chg = auto_s ^ auto_prev_q;

`ifdef STEP_DEBOUNCE_EN
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT} db_state_e;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

    db_state_e       state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Debounce state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Debounce next-state; counter only advances while waiting, any transition clears it
    always_comb begin
        state_d  = state_q;
        db_cnt_d = '0;
        man_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    man_req = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) state_d = REL_WAIT;
            end
            REL_WAIT: begin
                // Release bounce returns to PRESSED without a second request
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic btn_prev_q;
    logic man_req_q;

    // Registered rising-edge detect of the synchronised button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
            man_req_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_s;
            man_req_q  <= btn_s & ~btn_prev_q;
        end
    end

    assign man_req = man_req_q;
`endif

    logic [AUTO_W-1:0] div_q, div_d;
    logic              pending_q, pending_d;
    logic              step_pulse_q, step_pulse_d;
    logic [2:0]        stage_q, stage_d;
    logic              stage_wrap_q, stage_wrap_d;
    logic [WORD_W-1:0] ins_count_q, ins_count_d;
    logic              auto_req, req, issue;

    // Step issue, queueing and stage tracking
    always_comb begin
        div_d        = div_q;
        pending_d    = pending_q;
        step_pulse_d = 1'b0;
        stage_d      = stage_q;
        stage_wrap_d = 1'b0;
        ins_count_d  = ins_count_q;

        auto_req = auto_s && (div_q == AUTO_LAST);
        req      = auto_s ? auto_req : man_req;
        // A queued step from the previous mode is discarded on a mode switch
        issue    = ((pending_q && !mode_chg) || req) && !hold;

        if (!auto_s || mode_chg) begin
            div_d = '0;
        end else if (div_q == AUTO_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + AUTO_W'(1);
        end

        if (mode_chg || issue) begin
            pending_d = 1'b0;
        end else if (req) begin
            pending_d = 1'b1;
        end

        if (issue) begin
            step_pulse_d = 1'b1;
            if (stage_q == STAGE_LAST) begin
                stage_d      = 3'd0;
                stage_wrap_d = 1'b1;
                ins_count_d  = ins_count_q + WORD_W'(1);
            end else begin
                stage_d = stage_q + 3'd1;
            end
        end
    end

    // Main registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_q   <= '0;
            auto_sync_q  <= '0;
            auto_prev_q  <= 1'b0;
            div_q        <= '0;
            pending_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            stage_q      <= '0;
            stage_wrap_q <= 1'b0;
            ins_count_q  <= '0;
        end else begin
            btn_sync_q   <= {btn_sync_q[0], nextStage};
            auto_sync_q  <= {auto_sync_q[0], isAuto};
            auto_prev_q  <= auto_s;
            div_q        <= div_d;
            pending_q    <= pending_d;
            step_pulse_q <= step_pulse_d;
            stage_q      <= stage_d;
            stage_wrap_q <= stage_wrap_d;
            ins_count_q  <= ins_count_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign stage      = stage_q;
    assign stage_wrap = stage_wrap_q;
    assign ins_count  = ins_count_q;

endmodule

// File: tb/tb_stage_step_ctrl.sv
// Bench for stage_step_ctrl: directed vector table for button patterns plus hand-written
// sequences for reset, auto stepping, hold deferral and edge-mode latency.
// Expectations adapt to whether STEP_DEBOUNCE_EN is defined for the build.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_stage_step_ctrl;

    localparam int unsigned DB_COUNT  = 4;
    localparam int unsigned DB_W      = 4;
    localparam int unsigned AUTO_DIV  = 8;
    localparam int unsigned AUTO_W    = 4;
    localparam int unsigned STAGE_NUM = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  isAuto;
    logic                  nextStage;
    logic                  hold;
    logic                  step_pulse;
    logic [2:0]            stage;
    logic                  stage_wrap;
    logic [`WORD_SIZE-1:0] ins_count;

    always #5 clk = ~clk;

    stage_step_ctrl #(
        .DB_COUNT (DB_COUNT),
        .DB_W     (DB_W),
        .AUTO_DIV (AUTO_DIV),
        .AUTO_W   (AUTO_W),
        .STAGE_NUM(STAGE_NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .isAuto    (isAuto),
        .nextStage (nextStage),
        .hold      (hold),
        .step_pulse(step_pulse),
        .stage     (stage),
        .stage_wrap(stage_wrap),
        .ins_count (ins_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        isAuto    = 1'b0;
        nextStage = 1'b0;
        hold      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] bits(input int s, input int n);
        logic [63:0] r = '0;
        for (int i = s; i < s + n; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Raw button pattern (bit i = level in cycle i) and expected pulse counts per build
    typedef struct {
        logic [63:0] pat;
        int          len;
        int          p_db;
        int          p_raw;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    initial begin
        int np, nw, first, last, gaps_bad, exp_p;
        logic [63:0] p;

        vecs[0] = '{bits(0, 10), 20, 1, 1};                                  // clean press
        vecs[1] = '{bits(0, 1) | bits(2, 1) | bits(4, 10), 24, 1, 3};         // press bounce
        vecs[2] = '{bits(0, 3), 10, 0, 1};                                    // short glitch
        vecs[3] = '{bits(0, 8) | bits(10, 2), 24, 1, 2};                      // release bounce
        vecs[4] = '{bits(0, 6) | bits(12, 6) | bits(24, 6) | bits(36, 6) | bits(48, 6), 60, 5, 5};
        vecs[5] = '{64'd0, 10, 0, 0};                                         // idle

        // Reset state, observed before the first clock edge
        rst = 1'b1; isAuto = 1'b0; nextStage = 1'b0; hold = 1'b0;
        #2;
        chk("reset step_pulse", step_pulse, 0);
        chk("reset stage", stage, 0);
        chk("reset stage_wrap", stage_wrap, 0);
        chk("reset ins_count", ins_count, 0);
        tick();
        rst = 1'b0;

        // Table-driven button vectors, each from reset, followed by a flush
        for (int v = 0; v < NV; v++) begin
            do_reset();
            np = 0; nw = 0;
            p  = vecs[v].pat;
            for (int i = 0; i < vecs[v].len + 16; i++) begin
                nextStage = (i < vecs[v].len) ? p[i] : 1'b0;
                tick();
                np += int'(step_pulse);
                nw += int'(stage_wrap);
            end
`ifdef STEP_DEBOUNCE_EN
            exp_p = vecs[v].p_db;
`else
            exp_p = vecs[v].p_raw;
`endif
            chk($sformatf("vec%0d pulses", v), np, exp_p);
            chk($sformatf("vec%0d wraps", v), nw, exp_p / 5);
            chk($sformatf("vec%0d stage", v), stage, exp_p % 5);
            chk($sformatf("vec%0d ins_count", v), ins_count, exp_p / 5);
        end

        // One-cycle raw press: edge mode steps 4 cycles later, debounce rejects it
        do_reset();
        np = 0; first = -1;
        for (int i = 0; i < 15; i++) begin
            nextStage = (i == 0);
            tick();
            if (step_pulse) begin
                np++;
                if (first < 0) first = i + 1;
            end
        end
`ifdef STEP_DEBOUNCE_EN
        chk("short press pulses", np, 0);
        chk("short press latency", first, -1);
`else
        chk("short press pulses", np, 1);
        chk("short press latency", first, 4);
`endif

        // Reset mid-press: the held button must be re-qualified from scratch
        do_reset();
        np = 0;
        nextStage = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            np += int'(step_pulse);
        end
        chk("midpress pre-reset pulses", np, 0);
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        np = 0; first = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_pulse) begin
                np++;
                if (first < 0) first = i + 1;
            end
        end
        chk("midpress post-reset pulses", np, 1);
`ifdef STEP_DEBOUNCE_EN
        chk("midpress post-reset latency", first, 7);
`else
        chk("midpress post-reset latency", first, 4);
`endif
        nextStage = 1'b0;

        // Auto mode for 84 cycles, with a button press that must be ignored
        do_reset();
        np = 0; nw = 0; first = -1; last = -1; gaps_bad = 0;
        for (int i = 0; i < 96; i++) begin
            isAuto    = (i < 84);
            nextStage = (i >= 20 && i < 32);
            tick();
            nw += int'(stage_wrap);
            if (step_pulse) begin
                np++;
                if (first < 0) first = i + 1;
                if (last >= 0 && (i + 1 - last) != 8) gaps_bad++;
                last = i + 1;
            end
        end
        chk("auto pulses", np, 10);
        chk("auto first pulse", first, 11);
        chk("auto bad spacing", gaps_bad, 0);
        chk("auto wraps", nw, 2);
        chk("auto ins_count", ins_count, 2);
        chk("auto stage", stage, 0);

        // Hold across two auto requests: one queued step issues on release
        do_reset();
        isAuto = 1'b1;
        hold   = 1'b1;
        np = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            np += int'(step_pulse);
        end
        chk("hold pulses while held", np, 0);
        hold = 1'b0;
        tick();
        chk("hold release pulse", step_pulse, 1);
        np = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            np += int'(step_pulse);
        end
        chk("hold no second queued step", np, 0);
        chk("hold stage after release", stage, 1);
        tick();
        chk("hold next auto step", step_pulse, 1);
        chk("hold stage after next step", stage, 2);

        // Asynchronous reset mid-run at stage 3, ins_count 7 (38 steps)
        do_reset();
        isAuto = 1'b1;
        np = 0;
        for (int i = 0; i < 400 && np < 38; i++) begin
            tick();
            np += int'(step_pulse);
        end
        chk("run-up steps reached", np, 38);
        chk("run-up stage", stage, 3);
        chk("run-up ins_count", ins_count, 7);
        #3 rst = 1'b1;
        #1;
        chk("async reset step_pulse", step_pulse, 0);
        chk("async reset stage", stage, 0);
        chk("async reset stage_wrap", stage_wrap, 0);
        chk("async reset ins_count", ins_count, 0);
        isAuto = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
